// File: rtl/axil_mem_slave_v2_if.sv
// AXI4-Lite bus bundle for the generic memory slave.
// Master drives requests; slave drives READY/response channels.
interface axil_mem_slave_v2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARPROT, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARPROT, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axil_mem_slave_v2.sv
// AXI4-Lite word RAM slave: independent AW/W capture, byte strobes,
// read-only low window and optional privileged-only access.
module axil_mem_slave_v2 #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RO_WORDS   = 0,
  parameter bit                    PROT_CHECK = 1'b0
) (
  input logic                ACLK,
  input logic                ARESET,
  axil_mem_slave_v2_if.slave bus
);
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  live;
  logic                  aw_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_priv;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic                  rvalid;
  logic [1:0]            rresp;
  logic [DATA_WIDTH-1:0] rdata;

  // One extra bit keeps the borrow so addresses below the base miss.
  logic [ADDR_WIDTH:0]   aw_off;
  logic [ADDR_WIDTH:0]   ar_off;
  logic [ADDR_WIDTH-1:0] aw_word;
  logic [ADDR_WIDTH-1:0] ar_word;
  logic [IDX_W-1:0]      aw_idx;
  logic [IDX_W-1:0]      ar_idx;
  logic aw_hit, ar_hit, aw_ro;
  logic wr_err, rd_err;
  logic aw_hs, w_hs, ar_hs, commit;
  logic unused;

  assign aw_off  = {1'b0, aw_addr} - {1'b0, BASE_ADDR};
  assign ar_off  = {1'b0, bus.ARADDR} - {1'b0, BASE_ADDR};
  assign aw_word = aw_off[ADDR_WIDTH-1:0] >> BYTE_SH;
  assign ar_word = ar_off[ADDR_WIDTH-1:0] >> BYTE_SH;
  assign aw_idx  = aw_word[IDX_W-1:0];
  assign ar_idx  = ar_word[IDX_W-1:0];
  assign aw_hit  = !aw_off[ADDR_WIDTH] && (aw_word < DEPTH_A);
  assign ar_hit  = !ar_off[ADDR_WIDTH] && (ar_word < DEPTH_A);

  if (RO_WORDS > 0) begin : g_ro
    assign aw_ro = aw_word < ADDR_WIDTH'(RO_WORDS);
  end else begin : g_rw
    assign aw_ro = 1'b0;
  end

  assign wr_err = !aw_hit || aw_ro || (PROT_CHECK && !aw_priv);
  assign rd_err = !ar_hit || (PROT_CHECK && !bus.ARPROT[0]);

  assign bus.AWREADY = live && !aw_full;
  assign bus.WREADY  = live && !w_full;
  assign bus.ARREADY = live && (!rvalid || bus.RREADY);
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;
  assign bus.RVALID  = rvalid;
  assign bus.RRESP   = rresp;
  assign bus.RDATA   = rdata;

  assign aw_hs  = bus.AWVALID && bus.AWREADY;
  assign w_hs   = bus.WVALID && bus.WREADY;
  assign ar_hs  = bus.ARVALID && bus.ARREADY;
  assign commit = aw_full && w_full && (!bvalid || bus.BREADY);
  assign unused = ^{bus.AWPROT[2:1], bus.ARPROT[2:1]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      live    <= 1'b0;
      aw_full <= 1'b0;
      aw_addr <= '0;
      aw_priv <= 1'b0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      rvalid  <= 1'b0;
      rresp   <= OKAY;
      rdata   <= '0;
    end else begin
      live <= 1'b1;
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_err ? SLVERR : OKAY;
      end else begin
        if (aw_hs) begin
          aw_full <= 1'b1;
          aw_addr <= bus.AWADDR;
          aw_priv <= bus.AWPROT[0];
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_data <= bus.WDATA;
          w_strb <= bus.WSTRB;
        end
        if (bvalid && bus.BREADY) bvalid <= 1'b0;
      end
      if (ar_hs) begin
        rvalid <= 1'b1;
        rresp  <= rd_err ? SLVERR : OKAY;
        rdata  <= rd_err ? '0 : mem[ar_idx];
      end else if (bus.RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  // RAM is never reset; commit is low throughout reset.
  always_ff @(posedge ACLK) begin
    if (commit && !wr_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb[i]) mem[aw_idx][i*8 +: 8] <= w_data[i*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axil_mem_slave_v2.sv
// Directed bench: two slaves share stimulus, one plain and one with
// a read-only window plus privilege checking.
module tb_axil_mem_slave_v2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_mem_slave_v2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b0 ();
  axil_mem_slave_v2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();

  axil_mem_slave_v2 #(.BASE_ADDR(32'h1000)) dut0 (
    .ACLK(clk), .ARESET(rst), .bus(b0));
  axil_mem_slave_v2 #(
    .BASE_ADDR(32'h1000), .RO_WORDS(4), .PROT_CHECK(1'b1)
  ) dut1 (
    .ACLK(clk), .ARESET(rst), .bus(b1));

  assign b1.AWADDR  = b0.AWADDR;
  assign b1.AWPROT  = b0.AWPROT;
  assign b1.AWVALID = b0.AWVALID;
  assign b1.WDATA   = b0.WDATA;
  assign b1.WSTRB   = b0.WSTRB;
  assign b1.WVALID  = b0.WVALID;
  assign b1.BREADY  = b0.BREADY;
  assign b1.ARADDR  = b0.ARADDR;
  assign b1.ARPROT  = b0.ARPROT;
  assign b1.ARVALID = b0.ARVALID;
  assign b1.RREADY  = b0.RREADY;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [1:0]  b0;
    logic [1:0]  b1;
    logic [31:0] r0;
    logic [1:0]  rr0;
    logic [31:0] r1;
    logic [1:0]  rr1;
    bit          d1;
  } vec_t;

  vec_t vecs [16];
  int checks = 0;
  int errors = 0;

  logic [1:0]  r0, r1;
  logic [31:0] d0, d1;
  logic [1:0]  s0, s1;
  int          lat;
  int          cnt0, cnt1;
  logic [1:0]  q0 [2];
  logic [1:0]  q1 [2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hs_aw_w(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
    logic aa, wa;
    int n;
    b0.AWADDR = a; b0.AWPROT = p; b0.AWVALID = 1'b1;
    b0.WDATA = d; b0.WSTRB = s; b0.WVALID = 1'b1;
    n = 0;
    while ((b0.AWVALID || b0.WVALID) && n < 20) begin
      @(negedge clk);
      aa = b0.AWVALID && b0.AWREADY;
      wa = b0.WVALID && b0.WREADY;
      step();
      if (aa) b0.AWVALID = 1'b0;
      if (wa) b0.WVALID = 1'b0;
      n++;
    end
    if (n >= 20) chk("aw_w handshake timeout", 32'(n), 32'd0);
    b0.AWVALID = 1'b0;
    b0.WVALID = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [2:0] p,
                    output logic [1:0] o0, output logic [1:0] o1,
                    output int l);
    hs_aw_w(a, d, s, p);
    l = 0;
    while (l < 20) begin
      @(negedge clk);
      l++;
      if (b0.BVALID) break;
    end
    o0 = b0.BRESP;
    o1 = b1.BVALID ? b1.BRESP : 2'bxx;
    step();
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] p,
                    output logic [31:0] o0, output logic [31:0] o1,
                    output logic [1:0] e0, output logic [1:0] e1,
                    output int l);
    logic aa;
    int n;
    b0.ARADDR = a; b0.ARPROT = p; b0.ARVALID = 1'b1;
    n = 0;
    while (b0.ARVALID && n < 20) begin
      @(negedge clk);
      aa = b0.ARREADY;
      step();
      if (aa) b0.ARVALID = 1'b0;
      n++;
    end
    b0.ARVALID = 1'b0;
    l = 0;
    while (l < 20) begin
      @(negedge clk);
      l++;
      if (b0.RVALID) break;
    end
    o0 = b0.RDATA; e0 = b0.RRESP;
    o1 = b1.RVALID ? b1.RDATA : 32'hxxxxxxxx;
    e1 = b1.RVALID ? b1.RRESP : 2'bxx;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'd1, 2'd0, 2'd2,
                 32'hDEADBEEF, 2'd0, 32'h0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 32'h1014, 32'hFFFFFFFF, 4'hF, 3'd1, 2'd0, 2'd0,
                 32'hFFFFFFFF, 2'd0, 32'hFFFFFFFF, 2'd0, 1'b1};
    vecs[2]  = '{1'b1, 32'h1014, 32'h12345678, 4'h1, 3'd1, 2'd0, 2'd0,
                 32'hFFFFFF78, 2'd0, 32'hFFFFFF78, 2'd0, 1'b1};
    vecs[3]  = '{1'b1, 32'h1014, 32'hAABBCCDD, 4'hA, 3'd1, 2'd0, 2'd0,
                 32'hAAFFCC78, 2'd0, 32'hAAFFCC78, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 32'h1014, 32'h99999999, 4'h0, 3'd1, 2'd0, 2'd0,
                 32'hAAFFCC78, 2'd0, 32'hAAFFCC78, 2'd0, 1'b1};
    vecs[5]  = '{1'b1, 32'h1017, 32'h01020304, 4'hF, 3'd1, 2'd0, 2'd0,
                 32'h01020304, 2'd0, 32'h01020304, 2'd0, 1'b1};
    vecs[6]  = '{1'b1, 32'h1014, 32'h55555555, 4'hF, 3'd0, 2'd0, 2'd2,
                 32'h55555555, 2'd0, 32'h0, 2'd2, 1'b1};
    vecs[7]  = '{1'b0, 32'h1014, 32'h0, 4'h0, 3'd1, 2'd0, 2'd0,
                 32'h55555555, 2'd0, 32'h01020304, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 32'h1FFC, 32'h0BADF00D, 4'hF, 3'd1, 2'd0, 2'd0,
                 32'h0BADF00D, 2'd0, 32'h0BADF00D, 2'd0, 1'b1};
    vecs[9]  = '{1'b1, 32'h2000, 32'h11111111, 4'hF, 3'd1, 2'd2, 2'd2,
                 32'h0, 2'd2, 32'h0, 2'd2, 1'b1};
    vecs[10] = '{1'b0, 32'h1000, 32'h0, 4'h0, 3'd1, 2'd0, 2'd0,
                 32'hDEADBEEF, 2'd0, 32'h0, 2'd0, 1'b0};
    vecs[11] = '{1'b1, 32'h0FFC, 32'h22222222, 4'hF, 3'd1, 2'd2, 2'd2,
                 32'h0, 2'd2, 32'h0, 2'd2, 1'b1};
    vecs[12] = '{1'b1, 32'hFFFFFFFC, 32'h33333333, 4'hF, 3'd1, 2'd2, 2'd2,
                 32'h0, 2'd2, 32'h0, 2'd2, 1'b1};
    vecs[13] = '{1'b0, 32'h1FFC, 32'h0, 4'h0, 3'd1, 2'd0, 2'd0,
                 32'h0BADF00D, 2'd0, 32'h0BADF00D, 2'd0, 1'b1};
    vecs[14] = '{1'b1, 32'h100C, 32'h33333333, 4'hF, 3'd1, 2'd0, 2'd2,
                 32'h33333333, 2'd0, 32'h0, 2'd0, 1'b0};
    vecs[15] = '{1'b1, 32'h1010, 32'h44444444, 4'hF, 3'd1, 2'd0, 2'd0,
                 32'h44444444, 2'd0, 32'h44444444, 2'd0, 1'b1};

    b0.AWADDR = '0; b0.AWPROT = '0; b0.AWVALID = 1'b0;
    b0.WDATA = '0; b0.WSTRB = '0; b0.WVALID = 1'b0;
    b0.BREADY = 1'b1;
    b0.ARADDR = '0; b0.ARPROT = '0; b0.ARVALID = 1'b0;
    b0.RREADY = 1'b1;

    // reset values
    #12;
    chk("rst awready", 32'(b0.AWREADY), 32'd0);
    chk("rst wready", 32'(b0.WREADY), 32'd0);
    chk("rst arready", 32'(b0.ARREADY), 32'd0);
    chk("rst bvalid", 32'(b0.BVALID), 32'd0);
    chk("rst rvalid", 32'(b0.RVALID), 32'd0);
    chk("rst bresp", 32'(b0.BRESP), 32'd0);
    chk("rst rresp", 32'(b0.RRESP), 32'd0);
    chk("rst rdata", b0.RDATA, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready before edge", 32'({b0.AWREADY, b0.WREADY, b0.ARREADY}),
        32'd0);
    @(negedge clk);
    chk("ready after edge", 32'({b0.AWREADY, b0.WREADY, b0.ARREADY}),
        32'd7);
    chk("ready after edge dut1",
        32'({b1.AWREADY, b1.WREADY, b1.ARREADY}), 32'd7);
    step();

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        wr(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].prot,
           r0, r1, lat);
        chk($sformatf("v%0d bresp0", i), 32'(r0), 32'(vecs[i].b0));
        chk($sformatf("v%0d bresp1", i), 32'(r1), 32'(vecs[i].b1));
        chk($sformatf("v%0d blat", i), 32'(lat), 32'd2);
      end
      rd(vecs[i].addr, vecs[i].prot, d0, d1, s0, s1, lat);
      chk($sformatf("v%0d rdata0", i), d0, vecs[i].r0);
      chk($sformatf("v%0d rresp0", i), 32'(s0), 32'(vecs[i].rr0));
      chk($sformatf("v%0d rresp1", i), 32'(s1), 32'(vecs[i].rr1));
      if (vecs[i].d1)
        chk($sformatf("v%0d rdata1", i), d1, vecs[i].r1);
      chk($sformatf("v%0d rlat", i), 32'(lat), 32'd1);
    end

    // W three cycles ahead of AW
    b0.WDATA = 32'hCAFEBABE; b0.WSTRB = 4'hF; b0.WVALID = 1'b1;
    @(negedge clk);
    chk("s1 wready pre", 32'(b0.WREADY), 32'd1);
    step();
    b0.WVALID = 1'b0;
    @(negedge clk);
    chk("s1 wready held", 32'(b0.WREADY), 32'd0);
    step();
    step();
    b0.AWADDR = 32'h1010; b0.AWPROT = 3'd1; b0.AWVALID = 1'b1;
    @(negedge clk);
    chk("s1 awready", 32'(b0.AWREADY), 32'd1);
    chk("s1 bvalid early", 32'(b0.BVALID), 32'd0);
    step();
    b0.AWVALID = 1'b0;
    @(negedge clk);
    chk("s1 bvalid n", 32'(b0.BVALID), 32'd0);
    @(negedge clk);
    chk("s1 bvalid n+1", 32'({b0.BVALID, b1.BVALID}), 32'd3);
    chk("s1 bresp", 32'({b0.BRESP, b1.BRESP}), 32'd0);
    step();
    rd(32'h1010, 3'd1, d0, d1, s0, s1, lat);
    chk("s1 rdata0", d0, 32'hCAFEBABE);
    chk("s1 rdata1", d1, 32'hCAFEBABE);

    // back-pressured write responses
    b0.BREADY = 1'b0;
    wr(32'h1020, 32'h1, 4'hF, 3'd1, r0, r1, lat);
    chk("s2 first bresp", 32'(r0), 32'd0);
    hs_aw_w(32'h3000, 32'h2, 4'hF, 3'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("s2 stall%0d ready", k),
          32'({b0.AWREADY, b0.WREADY, b1.AWREADY, b1.WREADY}), 32'd0);
      chk($sformatf("s2 stall%0d b", k),
          32'({b0.BVALID, b0.BRESP}), 32'b100);
      step();
    end
    b0.BREADY = 1'b1;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b0.BVALID) begin
        if (cnt0 < 2) q0[cnt0] = b0.BRESP;
        cnt0++;
      end
      if (b1.BVALID) begin
        if (cnt1 < 2) q1[cnt1] = b1.BRESP;
        cnt1++;
      end
      step();
    end
    chk("s2 count0", 32'(cnt0), 32'd2);
    chk("s2 count1", 32'(cnt1), 32'd2);
    chk("s2 order0", 32'({q0[0], q0[1]}), 32'b0010);
    chk("s2 order1", 32'({q1[0], q1[1]}), 32'b0010);
    rd(32'h1020, 3'd1, d0, d1, s0, s1, lat);
    chk("s2 rdata0", d0, 32'h1);
    chk("s2 rdata1", d1, 32'h1);

    // reset in the middle of a buffered write
    wr(32'h1030, 32'h5A5A5A5A, 4'hF, 3'd1, r0, r1, lat);
    chk("s3 bresp", 32'({r0, r1}), 32'd0);
    b0.RREADY = 1'b0;
    rd(32'h1030, 3'd1, d0, d1, s0, s1, lat);
    chk("s3 rdata", d0, 32'h5A5A5A5A);
    @(negedge clk);
    chk("s3 rvalid held", 32'(b0.RVALID), 32'd1);
    chk("s3 rdata held", b0.RDATA, 32'h5A5A5A5A);
    chk("s3 arready stall", 32'(b0.ARREADY), 32'd0);
    step();
    hs_aw_w(32'h1030, 32'hFFFFFFFF, 4'hF, 3'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("s3 dut0 outs", 32'({b0.AWREADY, b0.WREADY, b0.ARREADY,
                             b0.BVALID, b0.RVALID}), 32'd0);
    chk("s3 dut1 outs", 32'({b1.AWREADY, b1.WREADY, b1.ARREADY,
                             b1.BVALID, b1.RVALID}), 32'd0);
    step();
    step();
    rst = 1'b0;
    b0.RREADY = 1'b1;
    step();
    rd(32'h1030, 3'd1, d0, d1, s0, s1, lat);
    chk("s3 kept0", d0, 32'h5A5A5A5A);
    chk("s3 kept1", d1, 32'h5A5A5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
